// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RISC-V control FSM with memory handshake, sticky trap and retire counter
module multicycle_control #(
  parameter int ALU_OP_W      = 2,
  parameter int SUPPORT_UPPER = 1,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_src,
  output logic                illegal,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    instret
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_UPPER    = 4'd4;
  localparam logic [3:0] S_ALU_WB   = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_JALR     = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2);

  // Upper-immediate opcodes are only legal when the build includes them.
  localparam logic [3:0] S_UPPER_OR_TRAP = (SUPPORT_UPPER != 0) ? S_UPPER : S_TRAP;

  logic [3:0]       state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  // Next-state logic; retire marks every instruction-completing return to FETCH.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_LUI, OP_AUIPC:   state_d = S_UPPER_OR_TRAP;
          default:            state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_UPPER: begin
        state_d = S_ALU_WB;
      end
      S_MEM_ADDR: begin
        // opcode[5] separates store (0100011) from load (0000011).
        state_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        // Encodings 14-15 recover to FETCH without counting a retirement.
        state_d = S_FETCH;
      end
    endcase
  end

  // Sticky trap flag and wrapping retired-instruction counter.
  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    instret_d = instret_q + CNT_W'(retire);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Moore control decode; reset forces every strobe and select low.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = ALU_ADD;
    pc_src     = 2'd0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_a = 2'd0;
          alu_src_b = 2'd2;
          alu_op    = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          pc_src    = 2'd0;
        end
        S_DECODE: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
          alu_op    = ALU_ADD;
        end
        S_EXEC_R: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd0;
          alu_op    = ALU_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          alu_op    = ALU_FUNCT;
        end
        S_UPPER: begin
          // LUI adds the immediate to zero, AUIPC to the instruction's PC.
          alu_src_a = opcode[5] ? 2'd3 : 2'd1;
          alu_src_b = 2'd1;
          alu_op    = ALU_ADD;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd0;
        end
        S_MEM_ADDR: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          alu_op    = ALU_ADD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd0;
          alu_op    = ALU_SUB;
          pc_src    = 2'd1;
          pc_write  = zero;
        end
        S_JAL: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd2;
          pc_write   = 1'b1;
          pc_src     = 2'd1;
        end
        S_JALR: begin
          // rd takes the current PC (already PC+4) while PC loads rs1+imm.
          alu_src_a  = 2'd2;
          alu_src_b  = 2'd1;
          alu_op     = ALU_ADD;
          pc_src     = 2'd0;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          mem_to_reg = 2'd2;
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs come straight from the registers.
  always_comb begin
    state   = state_q;
    illegal = illegal_q;
    instret = instret_q;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0]  st;
    logic [4:0]  stb;   // {pc_write, ir_write, mem_read, mem_write, reg_write}
    logic        iod;
    logic [1:0]  m2r;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [1:0]  op;
    logic [1:0]  ps;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        pcw_a, irw_a, iod_a, mr_a, mw_a, rw_a, ill_a;
  logic [1:0]  m2r_a, sa_a, sb_a, op_a, ps_a;
  logic [3:0]  st_a;
  logic [31:0] cnt_a;
  logic        pcw_b, irw_b, iod_b, mr_b, mw_b, rw_b, ill_b;
  logic [1:0]  m2r_b, sa_b, sb_b, op_b, ps_b;
  logic [3:0]  st_b;
  logic [31:0] cnt_b;

  exp_t act_a, act_b;
  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALU_OP_W(2), .SUPPORT_UPPER(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pcw_a), .ir_write(irw_a), .i_or_d(iod_a), .mem_read(mr_a),
    .mem_write(mw_a), .reg_write(rw_a), .mem_to_reg(m2r_a), .alu_src_a(sa_a),
    .alu_src_b(sb_a), .alu_op(op_a), .pc_src(ps_a), .illegal(ill_a),
    .state(st_a), .instret(cnt_a)
  );

  multicycle_control #(.ALU_OP_W(2), .SUPPORT_UPPER(0), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pcw_b), .ir_write(irw_b), .i_or_d(iod_b), .mem_read(mr_b),
    .mem_write(mw_b), .reg_write(rw_b), .mem_to_reg(m2r_b), .alu_src_a(sa_b),
    .alu_src_b(sb_b), .alu_op(op_b), .pc_src(ps_b), .illegal(ill_b),
    .state(st_b), .instret(cnt_b)
  );

  assign act_a = {st_a, pcw_a, irw_a, mr_a, mw_a, rw_a, iod_a, m2r_a, sa_a, sb_a, op_a, ps_a, ill_a, cnt_a};
  assign act_b = {st_b, pcw_b, irw_b, mr_b, mw_b, rw_b, iod_b, m2r_b, sa_b, sb_b, op_b, ps_b, ill_b, cnt_b};

  function automatic exp_t e(input logic [3:0] st, input logic [4:0] stb, input logic iod,
                             input logic [1:0] m2r, input logic [1:0] sa, input logic [1:0] sb,
                             input logic [1:0] op, input logic [1:0] ps, input logic ill,
                             input int cnt);
    exp_t r;
    r.st = st; r.stb = stb; r.iod = iod; r.m2r = m2r; r.sa = sa; r.sb = sb;
    r.op = op; r.ps = ps; r.ill = ill; r.cnt = 32'(cnt);
    return r;
  endfunction

  function automatic exp_t zv();           return e(4'd0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic exp_t frdy(input int c);  return e(4'd0, 5'b11100, 0, 0, 0, 2, 0, 0, 0, c); endfunction
  function automatic exp_t fwait(input int c); return e(4'd0, 5'b00100, 0, 0, 0, 2, 0, 0, 0, c); endfunction
  function automatic exp_t dec(input int c);   return e(4'd1, 5'b00000, 0, 0, 1, 1, 0, 0, 0, c); endfunction
  function automatic exp_t trap(input int c);  return e(4'd13, 5'b00000, 0, 0, 0, 0, 0, 0, 1, c); endfunction
  function automatic exp_t alu_wb(input int c); return e(4'd5, 5'b00001, 0, 0, 0, 0, 0, 0, 0, c); endfunction

  // Drive one cycle's inputs just after the edge and record what dut_a must show.
  task automatic step(input logic rst, input logic [6:0] op, input logic z, input logic mr,
                      input exp_t ea);
    @(posedge clk);
    #1;
    reset = rst; opcode = op; zero = z; mem_ready = mr;
    qa.push_back(ea);
  endtask

  task automatic stepb(input logic rst, input logic [6:0] op, input logic z, input logic mr,
                       input exp_t ea, input exp_t eb);
    @(posedge clk);
    #1;
    reset = rst; opcode = op; zero = z; mem_ready = mr;
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  // Monitor: pops and compares whenever an expectation is pending.
  always @(negedge clk) begin
    exp_t x;
    cyc <= cyc + 1;
    if (qa.size() > 0) begin
      x = qa.pop_front();
      checks = checks + 1;
      if (act_a !== x) begin
        failures = failures + 1;
        $display("FAIL dut_a cyc=%0d state got=%0d exp=%0d ctrl got=%h exp=%h instret got=%0d exp=%0d",
                 cyc, act_a.st, x.st, act_a[52:32], x[52:32], act_a.cnt, x.cnt);
      end
    end
    if (qb.size() > 0) begin
      x = qb.pop_front();
      checks = checks + 1;
      if (act_b !== x) begin
        failures = failures + 1;
        $display("FAIL dut_b cyc=%0d state got=%0d exp=%0d ctrl got=%h exp=%h instret got=%0d exp=%0d",
                 cyc, act_b.st, x.st, act_b[52:32], x[52:32], act_b.cnt, x.cnt);
      end
    end
  end

  initial begin
    // Reset held: everything low.
    step(1, OP_R, 0, 1, zv());
    step(1, OP_R, 0, 1, zv());

    // R-type: 0,1,2,5 then retire.
    step(0, OP_R, 0, 1, frdy(0));
    step(0, OP_R, 0, 1, dec(0));
    step(0, OP_R, 0, 1, e(4'd2, 5'b00000, 0, 0, 2, 0, 2, 0, 0, 0));
    step(0, OP_R, 0, 1, alu_wb(0));

    // Load with two wait cycles in MEM_RD; mem_ready ignored in DECODE/MEM_ADDR.
    step(0, OP_LD, 0, 1, frdy(1));
    step(0, OP_LD, 0, 0, dec(1));
    step(0, OP_LD, 0, 0, e(4'd6, 5'b00000, 0, 0, 2, 1, 0, 0, 0, 1));
    step(0, OP_LD, 0, 0, e(4'd7, 5'b00100, 1, 0, 0, 0, 0, 0, 0, 1));
    step(0, OP_LD, 0, 0, e(4'd7, 5'b00100, 1, 0, 0, 0, 0, 0, 0, 1));
    step(0, OP_LD, 0, 1, e(4'd7, 5'b00100, 1, 0, 0, 0, 0, 0, 0, 1));
    step(0, OP_LD, 0, 1, e(4'd8, 5'b00001, 0, 1, 0, 0, 0, 0, 0, 1));

    // Branch taken after one fetch wait, then not taken.
    step(0, OP_BR, 0, 0, fwait(2));
    step(0, OP_BR, 0, 1, frdy(2));
    step(0, OP_BR, 1, 1, dec(2));
    step(0, OP_BR, 1, 1, e(4'd10, 5'b10000, 0, 0, 2, 0, 1, 1, 0, 2));
    step(0, OP_BR, 0, 1, frdy(3));
    step(0, OP_BR, 0, 1, dec(3));
    step(0, OP_BR, 0, 1, e(4'd10, 5'b00000, 0, 0, 2, 0, 1, 1, 0, 3));

    // JAL then JALR.
    step(0, OP_JAL, 0, 1, frdy(4));
    step(0, OP_JAL, 0, 1, dec(4));
    step(0, OP_JAL, 0, 1, e(4'd11, 5'b10001, 0, 2, 0, 0, 0, 1, 0, 4));
    step(0, OP_JALR, 0, 1, frdy(5));
    step(0, OP_JALR, 0, 1, dec(5));
    step(0, OP_JALR, 0, 1, e(4'd12, 5'b10001, 0, 2, 2, 1, 0, 0, 0, 5));

    // Illegal opcode: trap holds for 10 cycles with no strobes.
    step(0, OP_BAD, 0, 1, frdy(6));
    step(0, OP_BAD, 0, 1, dec(6));
    for (int i = 0; i < 10; i++) step(0, OP_BAD, 0, 1, trap(6));
    step(1, OP_BAD, 0, 1, zv());

    // LUI: upper path on dut_a, trap on dut_b.
    stepb(0, OP_LUI, 0, 1, frdy(0), frdy(0));
    stepb(0, OP_LUI, 0, 1, dec(0), dec(0));
    stepb(0, OP_LUI, 0, 1, e(4'd4, 5'b00000, 0, 0, 3, 1, 0, 0, 0, 0), trap(0));
    stepb(0, OP_AUI, 0, 1, alu_wb(0), trap(0));
    step(0, OP_AUI, 0, 1, frdy(1));
    step(0, OP_AUI, 0, 1, dec(1));
    step(0, OP_AUI, 0, 1, e(4'd4, 5'b00000, 0, 0, 1, 1, 0, 0, 0, 1));
    step(0, OP_AUI, 0, 1, alu_wb(1));

    // Store stalled in MEM_WR, then reset asserted between edges.
    step(0, OP_ST, 0, 1, frdy(2));
    step(0, OP_ST, 0, 0, dec(2));
    step(0, OP_ST, 0, 0, e(4'd6, 5'b00000, 0, 0, 2, 1, 0, 0, 0, 2));
    step(0, OP_ST, 0, 0, e(4'd9, 5'b00010, 1, 0, 0, 0, 0, 0, 0, 2));
    step(1, OP_ST, 0, 0, zv());

    // Fetch resumes normally after release.
    step(0, OP_R, 0, 1, frdy(0));
    step(0, OP_R, 0, 1, dec(0));
    step(0, OP_R, 0, 1, e(4'd2, 5'b00000, 0, 0, 2, 0, 2, 0, 0, 0));
    step(0, OP_R, 0, 1, alu_wb(0));
    step(0, OP_R, 0, 0, fwait(1));

    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    #1;
    if (qa.size() > 0 || qb.size() > 0) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL drain pending got=%0d exp=0", qa.size() + qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
